// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA scan controller with pipeline-aligned sync and RGB.
// Optional VGA_TEST_PATTERN_EN adds pat_en, which replaces din with 8 vertical colour bars.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 4,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             pat_en,
`endif
    input  logic [3*CW-1:0]  din,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             read,
    output logic [CW-1:0]    R,
    output logic [CW-1:0]    G,
    output logic [CW-1:0]    B,
    output logic             HS,
    output logic             VS,
    output logic             frame_start,
    output logic             vblank
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HA0    = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] HA1    = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] VA0    = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] VA1    = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] HSW    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VSW    = CNT_W'(V_SYNC);
    localparam logic             HS_ON  = 1'(HS_POL);
    localparam logic             VS_ON  = 1'(VS_POL);

    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
    logic             read_q, read_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic             fs_q, fs_d, vb_q, vb_d, hs_q, hs_d, vs_q, vs_d;
    logic [3*CW-1:0]  rgb_q, rgb_d, pix;
    logic             h_wrap, h_act, v_act;

    always_comb begin
        h_wrap = hcnt_q == H_LAST;
        hcnt_d = pix_ce ? (h_wrap ? '0 : hcnt_q + 1'b1) : hcnt_q;
        vcnt_d = (pix_ce && h_wrap) ? (vcnt_q == V_LAST ? '0 : vcnt_q + 1'b1) : vcnt_q;
    end

    always_comb begin
        h_act  = (hcnt_q >= HA0) && (hcnt_q < HA1);
        v_act  = (vcnt_q >= VA0) && (vcnt_q < VA1);
        read_d = pix_ce ? (h_act && v_act) : read_q;
        col_d  = pix_ce ? ((h_act && v_act) ? hcnt_q - HA0 : '0) : col_q;
        row_d  = pix_ce ? ((h_act && v_act) ? vcnt_q - VA0 : '0) : row_q;
        hs1_d  = pix_ce ? ((hcnt_q < HSW) ? HS_ON : ~HS_ON) : hs1_q;
        vs1_d  = pix_ce ? ((vcnt_q < VSW) ? VS_ON : ~VS_ON) : vs1_q;
        fs_d   = pix_ce ? (hcnt_q == '0 && vcnt_q == '0) : fs_q;
        vb_d   = pix_ce ? !v_act : vb_q;
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
    logic [2:0] bar;
    // Bars are indexed from the stage-1 column so they line up with the read strobe.
    always_comb begin
        bar = 3'(col_q / BAR_W);
        pix = pat_en ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}} : din;
    end
`else
    always_comb pix = din;
`endif

    always_comb begin
        rgb_d = pix_ce ? (read_q ? pix : '0) : rgb_q;
        hs_d  = pix_ce ? hs1_q : hs_q;
        vs_d  = pix_ce ? vs1_q : vs_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            read_q <= 1'b0;
            hs1_q  <= ~HS_ON;
            vs1_q  <= ~VS_ON;
            fs_q   <= 1'b0;
            vb_q   <= 1'b1;
            rgb_q  <= '0;
            hs_q   <= ~HS_ON;
            vs_q   <= ~VS_ON;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            row_q  <= row_d;
            col_q  <= col_d;
            read_q <= read_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
            fs_q   <= fs_d;
            vb_q   <= vb_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
        end
    end

    assign row         = row_q;
    assign col         = col_q;
    assign read        = read_q;
    assign R           = rgb_q[CW-1:0];
    assign G           = rgb_q[2*CW-1:CW];
    assign B           = rgb_q[3*CW-1:2*CW];
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign frame_start = fs_q;
    assign vblank      = vb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks vga_timing_gen (small timing) against a scan-position model.
// The model derives every output from the count of pix_ce edges since reset.
module tb_vga_timing_gen;
    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 2;
    localparam int VA = 8, VFP = 1, VSY = 2, VBP = 2;
    localparam int CW = 4, CNW = 5;
    localparam logic HSP = 1'b0, VSP = 1'b1;
    localparam int HT = HSY + HBP + HA + HFP;
    localparam int VT = VSY + VBP + VA + VFP;
    localparam int FT = HT * VT;
    localparam int HA0 = HSY + HBP, VA0 = VSY + VBP;
    localparam int M = (1 << CW) - 1;

    logic clk = 1'b0, rst = 1'b1, pix_ce = 1'b0;
    logic [3*CW-1:0] din = '0;
`ifdef VGA_TEST_PATTERN_EN
    logic pat_en = 1'b0;
`endif
    logic [CNW-1:0] row, col;
    logic read, HS, VS, frame_start, vblank;
    logic [CW-1:0] R, G, B;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(int'(HSP)), .VS_POL(int'(VSP)), .CW(CW), .CNT_W(CNW)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
`ifdef VGA_TEST_PATTERN_EN
        .pat_en(pat_en),
`endif
        .din(din), .row(row), .col(col), .read(read),
        .R(R), .G(G), .B(B), .HS(HS), .VS(VS),
        .frame_start(frame_start), .vblank(vblank)
    );

    always #5 clk = ~clk;

    int n = 0;
    logic [3*CW-1:0] ldin = '0;
    logic lpat = 1'b0;
    int errors = 0, checks = 0;
    int prev_n = -1, hs_cnt = 0, vs_cnt = 0;
    logic cnt_done = 1'b0;
    logic fl_on = 1'b0, prev_fs = 1'b0;
    int clkcnt = 0, last_rise = -1, fl_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", nm, act, exp, n);
        end
    endtask

    function automatic int bars(input int c);
        int k;
        k = c / (HA / 8);
        return (((k & 4) != 0 ? M : 0) << (2 * CW)) | (((k & 2) != 0 ? M : 0) << CW) | ((k & 1) != 0 ? M : 0);
    endfunction

    function automatic logic active(input int h, input int v);
        return h >= HA0 && h < HA0 + HA && v >= VA0 && v < VA0 + VA;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else if (pix_ce) begin
            n <= n + 1;
            ldin <= din;
`ifdef VGA_TEST_PATTERN_EN
            lpat <= pat_en;
`else
            lpat <= 1'b0;
`endif
        end
    end

    always @(posedge clk) begin : cmp
        int p, h, v;
        int e_read, e_row, e_col, e_fs, e_vb, e_hs, e_vs, e_rgb;
        #1;
        e_read = 0; e_row = 0; e_col = 0; e_fs = 0; e_vb = 1;
        e_hs = int'(!HSP); e_vs = int'(!VSP); e_rgb = 0;
        if (n >= 1) begin
            p = (n - 1) % FT; h = p % HT; v = p / HT;
            e_read = int'(active(h, v));
            e_row = e_read != 0 ? v - VA0 : 0;
            e_col = e_read != 0 ? h - HA0 : 0;
            e_fs = int'(p == 0);
            e_vb = int'(!(v >= VA0 && v < VA0 + VA));
        end
        if (n >= 2) begin
            p = (n - 2) % FT; h = p % HT; v = p / HT;
            e_hs = h < HSY ? int'(HSP) : int'(!HSP);
            e_vs = v < VSY ? int'(VSP) : int'(!VSP);
            e_rgb = active(h, v) ? (lpat ? bars(h - HA0) : int'(ldin)) : 0;
        end
        chk("read", int'(read), e_read);
        chk("row", int'(row), e_row);
        chk("col", int'(col), e_col);
        chk("frame_start", int'(frame_start), e_fs);
        chk("vblank", int'(vblank), e_vb);
        chk("HS", int'(HS), e_hs);
        chk("VS", int'(VS), e_vs);
        chk("RGB", int'({B, G, R}), e_rgb);
        // Hand-derived anchors for this timing: first active at n=98, last at n=274, frame=299.
        if (n == 1) chk("pin_fs_first", int'(frame_start), 1);
        if (n == 300) chk("pin_fs_second", int'(frame_start), 1);
        if (n == 98) begin
            chk("pin_first_read", int'(read), 1);
            chk("pin_first_row", int'(row), 0);
            chk("pin_first_col", int'(col), 0);
        end
        if (n == 274) begin
            chk("pin_last_read", int'(read), 1);
            chk("pin_last_row", int'(row), 7);
            chk("pin_last_col", int'(col), 15);
        end
        if (n == 275) chk("pin_after_last_read", int'(read), 0);
`ifdef VGA_TEST_PATTERN_EN
        if (n >= 2 && lpat && ((n - 2) % FT) == VA0 * HT + HA0 + 2) begin
            chk("pin_bar1_R", int'(R), 15);
            chk("pin_bar1_G", int'(G), 0);
            chk("pin_bar1_B", int'(B), 0);
        end
`endif
        if (n != prev_n && n >= 301 && n <= 599) begin
            hs_cnt += int'(HS == HSP);
            vs_cnt += int'(VS == VSP);
        end
        if (n == 600 && !cnt_done) begin
            chk("hs_asserted_per_frame", hs_cnt, 39);
            chk("vs_asserted_per_frame", vs_cnt, 46);
            cnt_done = 1'b1;
        end
        prev_n = n;
        clkcnt++;
        if (fl_on && frame_start && !prev_fs) begin
            if (last_rise >= 0) begin
                chk("frame_len_clk", clkcnt - last_rise, 598);
                fl_seen++;
            end
            last_rise = clkcnt;
        end
        prev_fs = frame_start;
    end

    initial begin
        logic found;
        repeat (4) @(negedge clk);
        chk("rst_HS", int'(HS), 1);
        chk("rst_VS", int'(VS), 0);
        chk("rst_vblank", int'(vblank), 1);
        rst = 1'b0;
        pix_ce = 1'b1;
        repeat (700) begin
            @(negedge clk);
            din = 12'($urandom);
        end
        repeat (700) begin
            @(negedge clk);
            pix_ce = 1'($urandom % 2);
            din = 12'($urandom);
`ifdef VGA_TEST_PATTERN_EN
            pat_en = 1'($urandom % 2);
`endif
        end
        pix_ce = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            din = 12'($urandom);
            if (n >= 1 && ((n - 1) % FT) == 5 * HT + 10) found = 1'b1;
        end
        chk("midframe_window_found", int'(found), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_read", int'(read), 0);
        chk("async_rst_row", int'(row), 0);
        chk("async_rst_col", int'(col), 0);
        chk("async_rst_HS", int'(HS), 1);
        chk("async_rst_VS", int'(VS), 0);
        chk("async_rst_RGB", int'({B, G, R}), 0);
        chk("async_rst_fs", int'(frame_start), 0);
        chk("async_rst_vblank", int'(vblank), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("fs_after_release", int'(frame_start), 1);
        repeat (400) begin
            @(negedge clk);
            din = 12'($urandom);
        end
        fl_on = 1'b1;
        repeat (1300) begin
            @(negedge clk);
            pix_ce = ~pix_ce;
            din = 12'($urandom);
        end
        chk("frame_len_seen", int'(fl_seen > 0), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
